// File: rtl/cp0_unit_if.sv
// Core-to-CP0 bus: ID-stage control strobes in, read data, Status and redirect target out.
// timer_irq exists only when CP0_TIMER_EN is defined.
interface cp0_unit_if;
  logic        ena;
  logic        mfc0;
  logic        mtc0;
  logic        eret;
  logic        exception;
  logic [4:0]  cause;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic [31:0] status;
  logic [31:0] exc_addr;
  logic        exc_taken;
`ifdef CP0_TIMER_EN
  logic        timer_irq;
`endif

  modport master (
    output ena, mfc0, mtc0, eret, exception, cause, addr, wdata, pc,
    input  rdata, status, exc_addr, exc_taken
`ifdef CP0_TIMER_EN
    , input timer_irq
`endif
  );

  modport slave (
    input  ena, mfc0, mtc0, eret, exception, cause, addr, wdata, pc,
    output rdata, status, exc_addr, exc_taken
`ifdef CP0_TIMER_EN
    , output timer_irq
`endif
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file and exception sequencer for the pipelined MIPS core.
// Optional free-running Count/Compare timer is enabled with the CP0_TIMER_EN macro.
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_000F
) (
  input  logic     clk,
  input  logic     rst,
  cp0_unit_if.slave bus
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [31:0] status_q, cause_q, epc_q, count_q, compare_q;
  logic [31:0] cause_n, count_n, rdata_c;
  logic        mask, take, do_eret, do_mtc0;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  always_comb begin
    mask = 1'b0;
    case (bus.cause)
      5'd8:    mask = status_q[1];
      5'd9:    mask = status_q[2];
      5'd13:   mask = status_q[3];
      default: mask = 1'b0;
    endcase
  end

  // A taken exception drops eret and mtc0; eret drops mtc0.
  assign take       = bus.exception & bus.ena & status_q[0] & mask;
  assign do_eret    = bus.eret & bus.ena & ~take;
  assign do_mtc0    = bus.mtc0 & bus.ena & ~take & ~bus.eret;
  assign wr_count   = do_mtc0 && (bus.addr == REG_COUNT);
  assign wr_compare = do_mtc0 && (bus.addr == REG_COMPARE);
  assign wr_status  = do_mtc0 && (bus.addr == REG_STATUS);
  assign wr_cause   = do_mtc0 && (bus.addr == REG_CAUSE);
  assign wr_epc     = do_mtc0 && (bus.addr == REG_EPC);

  always_comb begin
    cause_n = cause_q;
    if (take)
      cause_n[6:2] = bus.cause;
    else if (wr_cause)
      cause_n = bus.wdata;
`ifdef CP0_TIMER_EN
    if (wr_compare)
      cause_n[15] = 1'b0;
    else if (count_q == compare_q)
      cause_n[15] = 1'b1;
`else
    cause_n[15] = 1'b0;
`endif
  end

  // Count keeps running while ID stalls; a direct write replaces this cycle's increment.
  always_comb begin
    count_n = count_q;
    if (wr_count)
      count_n = bus.wdata;
`ifdef CP0_TIMER_EN
    else
      count_n = count_q + 32'd1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q  <= STATUS_RST;
      cause_q   <= '0;
      epc_q     <= '0;
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
    end else begin
      cause_q <= cause_n;
      count_q <= count_n;
      if (take) begin
        epc_q    <= bus.pc;
        status_q <= status_q << 5;
      end else if (do_eret) begin
        status_q <= status_q >> 5;
      end else begin
        if (wr_status)  status_q  <= bus.wdata;
        if (wr_epc)     epc_q     <= bus.wdata;
        if (wr_compare) compare_q <= bus.wdata;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (bus.mfc0) begin
      case (bus.addr)
        REG_COUNT:   rdata_c = count_q;
        REG_COMPARE: rdata_c = compare_q;
        REG_STATUS:  rdata_c = status_q;
        REG_CAUSE:   rdata_c = cause_q;
        REG_EPC:     rdata_c = epc_q;
        default:     rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata     = rdata_c;
  assign bus.status    = status_q;
  assign bus.exc_taken = take;
  assign bus.exc_addr  = bus.eret ? epc_q : EXC_VECTOR;
`ifdef CP0_TIMER_EN
  assign bus.timer_irq = cause_q[15] & status_q[0];
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: a register-map model checked every cycle plus directed literals.
// Timer scenarios run only when CP0_TIMER_EN is defined.
module tb_cp0_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: CP0 state as a 32-entry map indexed by register number; unmapped entries stay zero.
  logic [31:0] m_reg [0:31];

  function automatic bit mapped(input logic [4:0] a);
    return (a == 5'd9) || (a == 5'd11) || (a == 5'd12) || (a == 5'd13) || (a == 5'd14);
  endfunction

  function automatic bit m_accept();
    bit enabled;
    enabled = 1'b0;
    if (bus.cause == 5'd8)  enabled = m_reg[12][1];
    if (bus.cause == 5'd9)  enabled = m_reg[12][2];
    if (bus.cause == 5'd13) enabled = m_reg[12][3];
    return bus.exception && bus.ena && m_reg[12][0] && enabled;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    logic [31:0] nr [0:31];
    bit acc, ert, wr;
    if (rst) begin
      for (int i = 0; i < 32; i++) nr[i] = '0;
      nr[12] = 32'h0000_000F;
      nr[11] = 32'hFFFF_FFFF;
    end else begin
      nr  = m_reg;
      acc = m_accept();
      ert = !acc && bus.ena && bus.eret;
      wr  = !acc && !ert && bus.ena && bus.mtc0 && !bus.eret && mapped(bus.addr);
      if (acc) begin
        nr[14]      = bus.pc;
        nr[13][6:2] = bus.cause;
        nr[12]      = m_reg[12] * 32;
      end else if (ert) begin
        nr[12] = m_reg[12] / 32;
      end else if (wr) begin
        nr[bus.addr] = bus.wdata;
      end
`ifdef CP0_TIMER_EN
      if (!(wr && bus.addr == 5'd9)) nr[9] = m_reg[9] + 1;
      if (wr && bus.addr == 5'd11) nr[13][15] = 1'b0;
      else if (m_reg[9] == m_reg[11]) nr[13][15] = 1'b1;
`else
      nr[13][15] = 1'b0;
`endif
    end
    m_reg <= nr;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model.rdata", bus.rdata, bus.mfc0 ? m_reg[bus.addr] : 32'h0);
      checkOutput("model.status", bus.status, m_reg[12]);
      checkOutput("model.exc_addr", bus.exc_addr, bus.eret ? m_reg[14] : 32'h0000_0004);
      checkOutput("model.exc_taken", {31'h0, bus.exc_taken}, {31'h0, m_accept()});
`ifdef CP0_TIMER_EN
      checkOutput("model.timer_irq", {31'h0, bus.timer_irq}, {31'h0, m_reg[13][15] & m_reg[12][0]});
`endif
    end
  end

  task automatic applyStimulus(input logic ena, input logic mfc0, input logic mtc0, input logic eret,
                               input logic exception, input logic [4:0] cause, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic [31:0] pc);
    @(posedge clk);
    #1;
    bus.ena = ena; bus.mfc0 = mfc0; bus.mtc0 = mtc0; bus.eret = eret;
    bus.exception = exception; bus.cause = cause; bus.addr = addr;
    bus.wdata = wdata; bus.pc = pc;
    @(negedge clk);
    #1;
  endtask

  task automatic readReg(input logic [4:0] a);
    applyStimulus(1, 1, 0, 0, 0, 5'd0, a, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.ena = 0; bus.mfc0 = 0; bus.mtc0 = 0; bus.eret = 0; bus.exception = 0;
    bus.cause = '0; bus.addr = '0; bus.wdata = '0; bus.pc = '0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    clk = 0; rst = 1; n_checks = 0; n_fail = 0;
    bus.ena = 0; bus.mfc0 = 0; bus.mtc0 = 0; bus.eret = 0; bus.exception = 0;
    bus.cause = '0; bus.addr = '0; bus.wdata = '0; bus.pc = '0;
    doReset();

    readReg(5'd12);
    checkOutput("reset.status_rd", bus.rdata, 32'h0000_000F);
    checkOutput("reset.exc_addr", bus.exc_addr, 32'h0000_0004);
    checkOutput("reset.exc_taken", {31'h0, bus.exc_taken}, 32'h0);
    readReg(5'd13);
    checkOutput("reset.cause_rd", bus.rdata, 32'h0);
    readReg(5'd11);
    checkOutput("reset.compare_rd", bus.rdata, 32'hFFFF_FFFF);

    // Syscall taken, then state inspected.
    applyStimulus(1, 0, 0, 0, 1, 5'd8, 5'd0, 32'h0, 32'h0040_0010);
    checkOutput("syscall.taken", {31'h0, bus.exc_taken}, 32'h1);
    checkOutput("syscall.exc_addr", bus.exc_addr, 32'h0000_0004);
    readReg(5'd14);
    checkOutput("syscall.epc", bus.rdata, 32'h0040_0010);
    checkOutput("syscall.status", bus.status, 32'h0000_01E0);
    readReg(5'd13);
    checkOutput("syscall.cause", bus.rdata, 32'h0000_0020);

    // Nested syscall blocked by IE=0, then eret.
    applyStimulus(1, 0, 0, 0, 1, 5'd8, 5'd0, 32'h0, 32'h0040_0020);
    checkOutput("nested.taken", {31'h0, bus.exc_taken}, 32'h0);
    readReg(5'd14);
    checkOutput("nested.epc", bus.rdata, 32'h0040_0010);
    applyStimulus(1, 0, 0, 1, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    checkOutput("eret.exc_addr", bus.exc_addr, 32'h0040_0010);
    readReg(5'd12);
    checkOutput("eret.status", bus.rdata, 32'h0000_000F);

    // Status = 0xB: teq enabled, break masked.
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd12, 32'h0000_000B, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 5'd13, 5'd0, 32'h0, 32'h0040_0100);
    checkOutput("teq.taken", {31'h0, bus.exc_taken}, 32'h1);
    applyStimulus(1, 0, 0, 1, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    checkOutput("teq.status", bus.status, 32'h0000_0160);
    checkOutput("teq.eret_addr", bus.exc_addr, 32'h0040_0100);
    applyStimulus(1, 0, 0, 0, 1, 5'd9, 5'd0, 32'h0, 32'h0040_0200);
    checkOutput("break.taken", {31'h0, bus.exc_taken}, 32'h0);
    checkOutput("break.status", bus.status, 32'h0000_000B);

    // Stalled ID: neither mtc0 nor exception may act.
    applyStimulus(0, 0, 1, 0, 1, 5'd13, 5'd14, 32'hDEAD_BEEF, 32'h0050_0000);
    checkOutput("stall.taken", {31'h0, bus.exc_taken}, 32'h0);
    readReg(5'd14);
    checkOutput("stall.epc", bus.rdata, 32'h0040_0100);

    // Exception beats mtc0 in the same cycle.
    applyStimulus(1, 0, 1, 0, 1, 5'd13, 5'd14, 32'hDEAD_BEEF, 32'h0050_0000);
    checkOutput("prio.taken", {31'h0, bus.exc_taken}, 32'h1);
    readReg(5'd14);
    checkOutput("prio.epc", bus.rdata, 32'h0050_0000);
    checkOutput("prio.status", bus.status, 32'h0000_0160);

    // eret beats mtc0: Status restored rather than cleared.
    applyStimulus(1, 0, 1, 1, 0, 5'd0, 5'd12, 32'h0, 32'h0);
    readReg(5'd12);
    checkOutput("eret_prio.status", bus.rdata, 32'h0000_000B);

    // Same-cycle write and read returns the old value; unmapped addresses read zero.
    applyStimulus(1, 1, 1, 0, 0, 5'd0, 5'd11, 32'h0000_1234, 32'h0);
    checkOutput("bypass.old", bus.rdata, 32'hFFFF_FFFF);
    readReg(5'd11);
    checkOutput("bypass.new", bus.rdata, 32'h0000_1234);
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd5, 32'h0000_0055, 32'h0);
    readReg(5'd5);
    checkOutput("unmapped.rd", bus.rdata, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd12, 32'h0, 32'h0);
    checkOutput("no_mfc0.rdata", bus.rdata, 32'h0);

    // Reset arriving while an exception is being taken.
    applyStimulus(1, 0, 0, 0, 1, 5'd13, 5'd0, 32'h0, 32'h0060_0000);
    checkOutput("midrst.taken", {31'h0, bus.exc_taken}, 32'h1);
    doReset();
    readReg(5'd14);
    checkOutput("midrst.epc", bus.rdata, 32'h0);
    checkOutput("midrst.status", bus.status, 32'h0000_000F);
    readReg(5'd13);
    checkOutput("midrst.cause", bus.rdata, 32'h0);

`ifdef CP0_TIMER_EN
    begin
      bit seen;
      doReset();
      applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd11, 32'h0000_0005, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        readReg(5'd13);
        seen = bus.timer_irq;
      end
      checkOutput("timer.irq_seen", {31'h0, seen}, 32'h1);
      checkOutput("timer.cause15", {31'h0, bus.rdata[15]}, 32'h1);
      applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd11, 32'h0000_0064, 32'h0);
      readReg(5'd13);
      checkOutput("timer.cleared", {31'h0, bus.rdata[15]}, 32'h0);
      checkOutput("timer.irq_clr", {31'h0, bus.timer_irq}, 32'h0);
    end
`else
    readReg(5'd9);
    checkOutput("count.static", bus.rdata, 32'h0);
`endif

    applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 register file and exception sequencer for the pipelined MIPS core.
- Acts on the ID-stage control strobes from the decoder: mfc0, mtc0, eret, exception and cause.
- Holds Status, Cause, EPC, Count and Compare.
- Decides whether a requested exception is taken and returns the redirect address that pc_select 3'b100 (eret) or 3'b101 (exception) selects.

Parameters:
- EXC_VECTOR, 32'h0000_0004, handler entry address returned when an exception is taken.
- STATUS_RST, 32'h0000_000F, reset value of Status (IE=1; syscall, break and teq enabled).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  pipeline advance; 0 = ID stalled, so no state update except Count.
- mfc0  in  1  read strobe.
- mtc0  in  1  write strobe.
- eret  in  1  exception return.
- exception  in  1  syscall, break or taken-teq request.
- cause  in  5  ExcCode: 8 = syscall, 9 = break, 13 = teq.
- addr  in  5  CP0 register number (instr rd field).
- wdata  in  32  mtc0 data (forwarded rt).
- pc  in  32  address of the ID-stage instruction.
- rdata  out  32  mfc0 read data.
- status  out  32  current Status.
- exc_addr  out  32  redirect target.
- exc_taken  out  1  exception accepted this cycle.

Behaviour:
- Register map:
  - 9 = Count.
  - 11 = Compare.
  - 12 = Status.
  - 13 = Cause; ExcCode in [6:2], timer pending IP7 in [15].
  - 14 = EPC.
  - Other addresses read 0; writes to them are ignored.
- Reset values: Status = STATUS_RST; Cause, EPC and Count = 0; Compare = 32'hFFFF_FFFF. Outputs settle to match: rdata = 0, exc_addr = EXC_VECTOR, exc_taken = 0.
- rdata:
  - Combinational on addr when mfc0 = 1; 0 otherwise.
  - No write bypass: an mtc0 and an mfc0 to the same register in the same cycle return the old value.
- Exception acceptance:
  - exc_taken = exception & ena & Status[0] & mask.
  - mask is Status[1] for cause 8, Status[2] for cause 9, Status[3] for cause 13; any other cause gives mask = 0.
  - exc_taken is purely combinational.
- Taken exception, at the clock edge:
  - EPC <= pc.
  - Cause[6:2] <= cause.
  - Status <= Status << 5, which saves the old mask and clears IE.
- A requested but masked exception changes no state.
- eret, at the clock edge when ena = 1: Status <= Status >> 5, restoring the saved mask.
- exc_addr:
  - EPC when eret = 1.
  - EXC_VECTOR otherwise, including on a masked request; the core gates pc_select itself.
- mtc0 with ena = 1: the addressed register <= wdata at the clock edge.
- Priority when several strobes are asserted together: exception > eret > mtc0. The lower-priority action is dropped entirely.
- With ena = 0, Status, Cause, EPC and Compare hold regardless of strobes.
- Reset mid-exception restores all reset values immediately; no partial EPC or Status update survives.
- Latency: every register update is visible on rdata and status one cycle after the edge.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined:
  - Count increments every cycle, independent of ena, wrapping from 32'hFFFF_FFFF to 0.
  - On Count == Compare, Cause[15] <= 1.
  - An mtc0 to Compare clears Cause[15].
  - An mtc0 to Count loads wdata and suppresses that cycle's increment.
  - Extra output timer_irq = Cause[15] & Status[0].
- When undefined:
  - Count and Compare are writable storage only; Count never auto-increments.
  - Cause[15] stays 0.
  - timer_irq is absent.

Test Plan:
- Reset, then mfc0 on addr 12 and on addr 13 -> rdata = 32'h0000_000F, then 0; exc_addr = 32'h0000_0004.
- exception = 1, cause = 8, pc = 32'h0040_0010, ena = 1 -> exc_taken = 1; next cycle EPC = 32'h0040_0010, Cause = 32'h0000_0020, Status = 32'h0000_01E0.
- Second syscall after that (IE = 0) -> exc_taken = 0; EPC unchanged. Then eret -> exc_addr = 32'h0040_0010 and next-cycle Status = 32'h0000_000F.
- mtc0 addr 12, wdata = 32'h0000_000B, then teq exception (cause = 13) -> exc_taken = 1; then break (cause = 9) after eret -> exc_taken = 0 (mask bit 2 clear).
- ena = 0 with mtc0 addr 14, wdata = 32'hDEAD_BEEF, and with exception -> EPC unchanged and exc_taken = 0; same stimulus with ena = 1 and both strobes -> exception wins and EPC = pc.
- CP0_TIMER_EN defined: mtc0 Compare = 5 at Count = 0 -> Cause[15] = 1 and timer_irq = 1 once Count reaches 5; mtc0 Compare = 100 -> Cause[15] = 0.
